// File: rtl/dance_pkg.sv
// Shared definitions for the dance-lane blocks: judgment codes seen by the score/streak
// updater, the judge's per-cycle action, and default timing parameters.
package dance_pkg;

    typedef enum logic [1:0] {
        JUDGE_NONE    = 2'b00,
        JUDGE_PERFECT = 2'b01,
        JUDGE_GOOD    = 2'b10,
        JUDGE_MISS    = 2'b11
    } judge_e;

    // What the judge does with the head note in a given cycle.
    typedef enum logic [1:0] {
        ACT_IDLE    = 2'b00,
        ACT_EXPIRE  = 2'b01,
        ACT_HIT     = 2'b10,
        ACT_DISCARD = 2'b11
    } act_e;

    localparam int TS_W_DEF        = 16;
    localparam int TRAVEL_DEF      = 500;
    localparam int PERFECT_WIN_DEF = 20;
    localparam int GOOD_WIN_DEF    = 60;
    localparam int DEPTH_DEF       = 4;

endpackage

// File: rtl/hit_judge_if.sv
// Lane-side signal bundle of the hit judge: timebase/spawn/button in, judgment and queue status out.
interface hit_judge_if #(
    parameter int DEPTH = dance_pkg::DEPTH_DEF
);
    import dance_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             tick_en;
    logic             note_spawn;
    logic             btn;
    judge_e           judge_sel;
    logic [CNT_W-1:0] pending_cnt;
    logic             q_full;
    logic             overflow_err;

    modport master (
        output tick_en, note_spawn, btn,
        input  judge_sel, pending_cnt, q_full, overflow_err
    );

    modport slave (
        input  tick_en, note_spawn, btn,
        output judge_sel, pending_cnt, q_full, overflow_err
    );

endinterface

// File: rtl/hit_judge_note_fifo.sv
// Synchronous FIFO of pending note target times; a push and a pop may share a cycle,
// including a push into a full FIFO that is being popped.
module note_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [W-1:0]           din_i,
    output logic [W-1:0]           head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == FULL_CNT);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (do_pop)  rd_d = rd_q + 1'b1;
        if (do_push) wr_d = wr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: the count alone says which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

endmodule

// File: rtl/hit_judge.sv
// Timing judge for one dance lane: timestamps spawns, queues target times and grades
// button presses against the oldest pending note with a one-cycle judgment code.
module hit_judge
    import dance_pkg::*;
#(
    parameter int TS_W        = TS_W_DEF,
    parameter int TRAVEL      = TRAVEL_DEF,
    parameter int PERFECT_WIN = PERFECT_WIN_DEF,
    parameter int GOOD_WIN    = GOOD_WIN_DEF,
    parameter int DEPTH       = DEPTH_DEF
) (
    input  logic       clk,
    input  logic       reset,
    hit_judge_if.slave bus
);
    localparam int                     CNT_W    = $clog2(DEPTH) + 1;
    localparam logic [TS_W-1:0]        TRAVEL_U = TS_W'(TRAVEL);
    localparam logic [TS_W-1:0]        PERF_U   = TS_W'(PERFECT_WIN);
    localparam logic [TS_W-1:0]        GOOD_U   = TS_W'(GOOD_WIN);
    localparam logic signed [TS_W-1:0] GOOD_S   = TS_W'(GOOD_WIN);

    function automatic logic [TS_W-1:0] abs_ts(input logic signed [TS_W-1:0] v);
        logic [TS_W-1:0] u;
        u = v;
        return v[TS_W-1] ? (~u + 1'b1) : u;
    endfunction

    logic [TS_W-1:0]        now_q, now_d;
    logic                   btn_q;
    logic                   press_q, press_d;
    judge_e                 judge_q, judge_d;
    logic                   ovf_q, ovf_d;

    logic [TS_W-1:0]        head;
    logic [CNT_W-1:0]       count;
    logic                   full;
    logic                   empty;
    logic signed [TS_W-1:0] diff;
    logic [TS_W-1:0]        mag;
    logic                   rise;
    logic                   pop;
    logic                   push;
    act_e                   act;

    note_fifo #(
        .DEPTH (DEPTH),
        .W     (TS_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (now_q + TRAVEL_U),
        .head_o  (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    // Modular difference; the travel/window bound keeps it unambiguous across wrap.
    assign diff = $signed(now_q - head);
    assign mag  = abs_ts(diff);
    assign rise = bus.btn & ~btn_q;

    always_comb begin
        act = ACT_IDLE;
        if (!empty && diff > GOOD_S)
            act = ACT_EXPIRE;
        else if (press_q && !empty && mag <= GOOD_U)
            act = ACT_HIT;
        else if (press_q && (empty || diff < -GOOD_S))
            act = ACT_DISCARD;
    end

    always_comb begin
        case (act)
            ACT_EXPIRE: judge_d = JUDGE_MISS;
            ACT_HIT:    judge_d = (mag <= PERF_U) ? JUDGE_PERFECT : JUDGE_GOOD;
            default:    judge_d = JUDGE_NONE;
        endcase
    end

    assign pop   = (act == ACT_EXPIRE) || (act == ACT_HIT);
    assign push  = bus.note_spawn && (!full || pop);
    assign ovf_d = ovf_q | (bus.note_spawn & full & ~pop);
    assign now_d = bus.tick_en ? now_q + 1'b1 : now_q;

    // A fresh edge always arms; an expiry leaves an armed press for the next cycle.
    always_comb begin
        press_d = press_q;
        if (rise)
            press_d = 1'b1;
        else if (act == ACT_HIT || act == ACT_DISCARD)
            press_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            now_q   <= '0;
            btn_q   <= 1'b0;
            press_q <= 1'b0;
            judge_q <= JUDGE_NONE;
            ovf_q   <= 1'b0;
        end else begin
            now_q   <= now_d;
            btn_q   <= bus.btn;
            press_q <= press_d;
            judge_q <= judge_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.judge_sel    = judge_q;
    assign bus.pending_cnt  = count;
    assign bus.q_full       = full;
    assign bus.overflow_err = ovf_q;

endmodule

// File: tb/tb_hit_judge.sv
// Directed and randomised checks of hit_judge against a queue-of-targets model of the lane rules.
`timescale 1ns/1ps
module tb_hit_judge;
    import dance_pkg::*;

    localparam int TRAVEL = 500;
    localparam int PERF   = 20;
    localparam int GOOD   = 60;
    localparam int DEPTH  = 4;
    localparam int MOD    = 65536;

    typedef struct { int cyc; logic [1:0] code; } jexp_t;
    typedef struct { logic [2:0] cnt; logic full; logic ovf; } sexp_t;

    logic  clk;
    logic  reset;
    int    ncyc;
    int    checks;
    int    failures;
    jexp_t jq[$];
    sexp_t sq[$];

    // Reference model state
    int m_now;
    int m_tq[$];
    bit m_pp;
    bit m_bq;
    bit m_ovf;

    int offs [4];
    int codes[4];

    hit_judge_if #(.DEPTH(DEPTH)) bus();
    hit_judge dut (.clk(clk), .reset(reset), .bus(bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) ncyc <= ncyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sdiff(input int now, input int tgt);
        int d;
        d = (now - tgt + MOD) % MOD;
        if (d >= MOD / 2) d -= MOD;
        return d;
    endfunction

    task automatic model_step(input bit spawn, input bit b, input bit tick);
        logic [1:0] code;
        bit pop, used, full;
        int d, ad, tgt;
        code = 2'b00; pop = 0; used = 0; d = 0; ad = 0;
        full = (m_tq.size() == DEPTH);
        tgt  = (m_now + TRAVEL) % MOD;
        if (m_tq.size() != 0) begin
            d  = sdiff(m_now, m_tq[0]);
            ad = (d < 0) ? -d : d;
        end
        if (m_tq.size() != 0 && d > GOOD) begin
            code = 2'b11; pop = 1;
        end else if (m_pp && m_tq.size() != 0 && ad <= GOOD) begin
            code = (ad <= PERF) ? 2'b01 : 2'b10; pop = 1; used = 1;
        end else if (m_pp && (m_tq.size() == 0 || d < -GOOD)) begin
            used = 1;
        end
        if (pop) m_tq.delete(0);
        if (spawn) begin
            if (full && !pop) m_ovf = 1;
            else m_tq.push_back(tgt);
        end
        if (b && !m_bq) m_pp = 1;
        else if (used) m_pp = 0;
        m_bq = b;
        if (tick) m_now = (m_now + 1) % MOD;
        if (code != 2'b00) jq.push_back('{ncyc + 1, code});
        sq.push_back('{3'(m_tq.size()), m_tq.size() == DEPTH, m_ovf});
    endtask

    task automatic cyc(input bit spawn, input bit b, input bit tick);
        @(negedge clk);
        reset          = 1'b1;
        bus.note_spawn = spawn;
        bus.btn        = b;
        bus.tick_en    = tick;
        model_step(spawn, b, tick);
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset          = 1'b0;
        bus.note_spawn = 1'b0;
        bus.btn        = 1'b0;
        bus.tick_en    = 1'b0;
        #1;
        check({tag, "_judge"}, bus.judge_sel, 0);
        check({tag, "_cnt"},   bus.pending_cnt, 0);
        check({tag, "_full"},  bus.q_full, 0);
        check({tag, "_ovf"},   bus.overflow_err, 0);
        m_now = 0; m_tq.delete(); m_pp = 0; m_bq = 0; m_ovf = 0;
        jq.delete(); sq.delete();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_to(input int t);
        int n;
        n = 0;
        while (m_now != t && n < 70000) begin
            cyc(1'b0, 1'b0, 1'b1);
            n++;
        end
        if (m_now != t) begin
            checks++; failures++;
            $display("FAIL idle_to: now %0d target %0d", m_now, t);
        end
    endtask

    // Edge one cycle before, so the press is evaluated when now == t.
    task automatic press_eval_at(input int t);
        idle_to((t - 1 + MOD) % MOD);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
    endtask

    // Monitor: status every cycle, judgments whenever one is due or presented
    initial begin
        jexp_t e;
        sexp_t s;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                if (sq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL status_underflow at cycle %0d", ncyc);
                end else begin
                    s = sq.pop_front();
                    check("status", {bus.pending_cnt, bus.q_full, bus.overflow_err},
                          {s.cnt, s.full, s.ovf});
                end
                if (jq.size() != 0 && jq[0].cyc == ncyc) begin
                    e = jq.pop_front();
                    check("judge", bus.judge_sel, e.code);
                end else if (bus.judge_sel != 2'b00) begin
                    checks++; failures++;
                    $display("FAIL judge_spurious: got %0d expected 0 at cycle %0d", bus.judge_sel, ncyc);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        bit b;
        offs  = '{20, -20, 21, 60};
        codes = '{1, 1, 2, 2};
        reset = 1'b0;
        bus.tick_en = 1'b0; bus.note_spawn = 1'b0; bus.btn = 1'b0;
        do_reset("rst0");

        // Spawn at now=0, press at now=500
        cyc(1'b1, 1'b0, 1'b1);
        check("t1_cnt_spawn", bus.pending_cnt, 1);
        press_eval_at(500);
        check("t1_perfect", bus.judge_sel, 1);
        check("t1_cnt_hit", bus.pending_cnt, 0);
        cyc(1'b0, 1'b0, 1'b1);
        check("t1_one_cycle", bus.judge_sel, 0);

        // Window edges
        for (int i = 0; i < 4; i++) begin
            base = m_now;
            cyc(1'b1, 1'b0, 1'b1);
            press_eval_at((base + TRAVEL + offs[i]) % MOD);
            check($sformatf("t2_off%0d", offs[i]), bus.judge_sel, codes[i]);
        end

        // Unpressed note expires at d=+61
        base = m_now;
        cyc(1'b1, 1'b0, 1'b1);
        idle_to((base + 561) % MOD);
        check("t3_no_miss_at_60", bus.judge_sel, 0);
        cyc(1'b0, 1'b0, 1'b1);
        check("t3_miss", bus.judge_sel, 3);
        check("t3_cnt", bus.pending_cnt, 0);

        // Too-early press is ignored, then a hit
        base = m_now;
        cyc(1'b1, 1'b0, 1'b1);
        press_eval_at((base + 439) % MOD);
        check("t4_early_none", bus.judge_sel, 0);
        check("t4_still_queued", bus.pending_cnt, 1);
        press_eval_at((base + 500) % MOD);
        check("t4_perfect", bus.judge_sel, 1);

        // Empty-queue press, then overflow
        press_eval_at((m_now + 5) % MOD);
        check("t5_empty_none", bus.judge_sel, 0);
        repeat (5) cyc(1'b1, 1'b0, 1'b1);
        check("t5_cnt", bus.pending_cnt, 4);
        check("t5_full", bus.q_full, 1);
        check("t5_ovf", bus.overflow_err, 1);
        idle_to((m_now + 600) % MOD);
        check("t5_ovf_sticky", bus.overflow_err, 1);
        check("t5_drained", bus.pending_cnt, 0);
        do_reset("t5rst");

        // Timestamp wrap
        idle_to(65300);
        cyc(1'b1, 1'b0, 1'b1);
        press_eval_at(270);
        check("t6_wrap_perfect", bus.judge_sel, 1);
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        check("t6_cnt", bus.pending_cnt, 2);
        do_reset("t6rst");

        // Randomised traffic against the model
        b = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset("rnd_rst");
            if ($urandom_range(0, 7) == 0) b = ~b;
            cyc($urandom_range(0, 149) == 0, b, $urandom_range(0, 3) != 0);
        end
        repeat (4) cyc(1'b0, 1'b0, 1'b1);
        check("sb_drain", jq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
